// File: rtl/id_stage_pipe_pkg.sv
// Shared LEGv8 decode definitions: format enum, opcode constants and the ID/EX payload.
package id_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned DATA_W = 64;  // ID/EX data fields are sized for the widest XLEN
    localparam int unsigned RIDX_W = 5;   // LEGv8 register fields are 5 bits

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_D,
        FMT_CB,
        FMT_B
    } fmt_e;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [6:0]  OP_CBX  = 7'b1011010;     // CBZ and CBNZ differ only in bit 24
    localparam logic [5:0]  OP_B    = 6'b000101;

    typedef struct packed {
        logic                valid;
        logic                is_load;
        logic [DATA_W-1:0]   pc;
        logic [DATA_W-1:0]   rdata1;
        logic [DATA_W-1:0]   rdata2;
        logic [DATA_W-1:0]   imm;
        logic [RIDX_W-1:0]   rd;
        logic [RIDX_W-1:0]   rn;
        logic [RIDX_W-1:0]   r2;
    } id_ex_t;

    // Classify an instruction word by its opcode field.
    function automatic fmt_e decode_fmt(input logic [INST_W-1:0] inst);
        fmt_e f;
        if (inst[31:26] == OP_B) begin
            f = FMT_B;
        end else if (inst[31:25] == OP_CBX) begin
            f = FMT_CB;
        end else if ((inst[31:21] == OP_LDUR) || (inst[31:21] == OP_STUR)) begin
            f = FMT_D;
        end else if ((inst[31:22] == OP_ADDI) || (inst[31:22] == OP_SUBI)) begin
            f = FMT_I;
        end else begin
            f = FMT_R;
        end
        return f;
    endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// Two-read/one-write register file; top index is XZR (reads 0, writes dropped).
// Write-through of the write port onto the read ports is enabled by ID_BYPASS_EN.
module regfile_2r1w #(
    parameter  int unsigned XLEN = 64,
    parameter  int unsigned NREG = 32,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    localparam logic [AW-1:0] XZR = AW'(NREG - 1);

    logic [XLEN-1:0] regs_q [NREG];

    // Storage: cleared on reset, written on the rising edge except at XZR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != XZR)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read port 1: array lookup, optional write-through, XZR forced to zero.
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
`ifdef ID_BYPASS_EN
        if (we_i && (raddr1_i == waddr_i)) begin
            rdata1_o = wdata_i;
        end
`endif
        if (raddr1_i == XZR) begin
            rdata1_o = '0;
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        rdata2_o = regs_q[raddr2_i];
`ifdef ID_BYPASS_EN
        if (we_i && (raddr2_i == waddr_i)) begin
            rdata2_o = wdata_i;
        end
`endif
        if (raddr2_i == XZR) begin
            rdata2_o = '0;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// LEGv8 pipelined decode stage: decode, immediate extension, load-use stall and ID/EX register.
// Optional macro ID_BYPASS_EN: register-file write-through on same-cycle write/read.
// XLEN is limited to 64 (ID/EX payload width).
module id_stage_pipe
    import id_pkg::*;
#(
    parameter  int unsigned XLEN = 64,
    parameter  int unsigned NREG = 32,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rdata1,
    output logic [XLEN-1:0] ex_rdata2,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rd,
    output logic [AW-1:0]   ex_rn,
    output logic [AW-1:0]   ex_r2,
    output logic            ex_is_load
);

    localparam logic [AW-1:0] XZR = AW'(NREG - 1);

    fmt_e              fmt;
    logic              is_ldur;
    logic              is_stur;
    logic              uses_r2;
    logic [DATA_W-1:0] imm_ext;
    logic [AW-1:0]     rn_idx;
    logic [AW-1:0]     r2_idx;
    logic [AW-1:0]     rd_idx;
    logic [XLEN-1:0]   rf_rdata1;
    logic [XLEN-1:0]   rf_rdata2;
    logic [AW-1:0]     ex_rd_idx;
    logic              hazard;
    logic              accept;
    id_ex_t            ex_d;
    id_ex_t            ex_q;

    // Decode format, register indices and the extended immediate of the incoming word.
    always_comb begin
        fmt     = decode_fmt(if_inst);
        is_ldur = (if_inst[31:21] == OP_LDUR);
        is_stur = (if_inst[31:21] == OP_STUR);
        uses_r2 = (fmt == FMT_R) || (fmt == FMT_CB) || is_stur;
        rn_idx  = AW'(if_inst[9:5]);
        rd_idx  = AW'(if_inst[4:0]);
        r2_idx  = ((fmt == FMT_CB) || is_stur) ? AW'(if_inst[4:0]) : AW'(if_inst[20:16]);
        case (fmt)
            FMT_B:   imm_ext = {{38{if_inst[25]}}, if_inst[25:0]};
            FMT_CB:  imm_ext = {{45{if_inst[23]}}, if_inst[23:5]};
            FMT_D:   imm_ext = {{55{if_inst[20]}}, if_inst[20:12]};
            FMT_I:   imm_ext = {52'd0, if_inst[21:10]};
            default: imm_ext = {58'd0, if_inst[15:10]};
        endcase
    end

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (rn_idx),
        .rdata1_o (rf_rdata1),
        .raddr2_i (r2_idx),
        .rdata2_o (rf_rdata2),
        .we_i     (wb_we),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    // Load-use check; the Rn field is compared for every format, which only over-stalls B/CB.
    // The resulting bubble clears ex_valid, so a stall never lasts more than one cycle.
    always_comb begin
        ex_rd_idx = AW'(ex_q.rd);
        hazard    = ex_q.valid && ex_q.is_load && (ex_rd_idx != XZR) && if_valid &&
                    ((rn_idx == ex_rd_idx) || (uses_r2 && (r2_idx == ex_rd_idx)));
        if_ready  = flush || !hazard;
        accept    = if_valid && if_ready && !flush;
    end

    // Next ID/EX contents: load on accept, otherwise bubble with payload held.
    always_comb begin
        ex_d       = ex_q;
        ex_d.valid = 1'b0;
        if (accept) begin
            ex_d.valid   = 1'b1;
            ex_d.is_load = is_ldur;
            ex_d.pc      = DATA_W'(if_pc);
            ex_d.rdata1  = DATA_W'(rf_rdata1);
            ex_d.rdata2  = DATA_W'(rf_rdata2);
            ex_d.imm     = imm_ext;
            ex_d.rd      = RIDX_W'(rd_idx);
            ex_d.rn      = RIDX_W'(rn_idx);
            ex_d.r2      = RIDX_W'(r2_idx);
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_is_load = ex_q.is_load;
    assign ex_pc      = XLEN'(ex_q.pc);
    assign ex_rdata1  = XLEN'(ex_q.rdata1);
    assign ex_rdata2  = XLEN'(ex_q.rdata2);
    assign ex_imm     = XLEN'(ex_q.imm);
    assign ex_rd      = AW'(ex_q.rd);
    assign ex_rn      = AW'(ex_q.rn);
    assign ex_r2      = AW'(ex_q.r2);

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed vector table, hand-written
// flush/reset sequences and randomized traffic against a reference model.
module tb_id_stage_pipe;

`ifdef ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_ready, flush, wb_we;
    logic [31:0] if_inst;
    logic [63:0] if_pc, wb_data;
    logic [4:0]  wb_addr;
    logic        ex_valid, ex_is_load;
    logic [63:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rd, ex_rn, ex_r2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(64), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_inst(if_inst), .if_pc(if_pc), .flush(flush), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_rn(ex_rn), .ex_r2(ex_r2), .ex_is_load(ex_is_load)
    );

    typedef struct {
        logic [31:0] inst;
        logic        valid;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        rdy;
        logic        vld;
        logic [63:0] imm, rd1, rd2;
        logic [4:0]  rn, r2, rd;
        logic        ld;
    } vec_t;

    typedef struct {
        logic        valid, is_load;
        logic [63:0] pc, rdata1, rdata2, imm;
        logic [4:0]  rd, rn, r2;
    } mex_t;

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  rn, r2, rd;
        logic        uses_r2, is_load;
    } dec_t;

    logic [63:0] m_regs [32];
    mex_t        m_ex;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [63:0] pc, input logic v,
                         input logic fl, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd);
        if_inst = inst; if_pc = pc; if_valid = v; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ex_valid"},  64'(ex_valid), 64'd0);
        chk({tag, " ex_is_load"}, 64'(ex_is_load), 64'd0);
        chk({tag, " ex_pc"},     ex_pc, 64'd0);
        chk({tag, " ex_rdata1"}, ex_rdata1, 64'd0);
        chk({tag, " ex_rdata2"}, ex_rdata2, 64'd0);
        chk({tag, " ex_imm"},    ex_imm, 64'd0);
        chk({tag, " ex_rd/rn/r2"}, 64'({ex_rd, ex_rn, ex_r2}), 64'd0);
        chk({tag, " if_ready"},  64'(if_ready), 64'd1);
    endtask

    function automatic vec_t mkv(logic [31:0] inst, logic valid, logic we, logic [4:0] wa,
                                 logic [63:0] wd, logic rdy, logic vld, logic [63:0] imm,
                                 logic [63:0] rd1, logic [63:0] rd2, logic [4:0] rn,
                                 logic [4:0] r2, logic [4:0] rd, logic ld);
        vec_t v;
        v.inst = inst; v.valid = valid; v.we = we; v.wa = wa; v.wd = wd; v.rdy = rdy;
        v.vld = vld; v.imm = imm; v.rd1 = rd1; v.rd2 = rd2; v.rn = rn; v.r2 = r2;
        v.rd = rd; v.ld = ld;
        return v;
    endfunction

    // Sign-extend the low n bits of v.
    function automatic logic [63:0] sext(logic [63:0] v, int n);
        logic signed [63:0] t;
        t = $signed(v << (64 - n));
        return 64'(t >>> (64 - n));
    endfunction

    // Reference decode written from the format rules.
    function automatic dec_t mdec(logic [31:0] x);
        dec_t d;
        logic is_b, is_cb, is_ld, is_st, is_i;
        is_b  = (x[31:26] == 6'b000101);
        is_cb = (x[31:25] == 7'b1011010);
        is_ld = (x[31:21] == 11'b11111000010);
        is_st = (x[31:21] == 11'b11111000000);
        is_i  = (x[31:22] == 10'b1001000100) || (x[31:22] == 10'b1101000100);
        if (is_b)                d.imm = sext(64'(x[25:0]), 26);
        else if (is_cb)          d.imm = sext(64'(x[23:5]), 19);
        else if (is_ld || is_st) d.imm = sext(64'(x[20:12]), 9);
        else if (is_i)           d.imm = 64'(x[21:10]);
        else                     d.imm = 64'(x[15:10]);
        d.rn      = x[9:5];
        d.rd      = x[4:0];
        d.r2      = (is_cb || is_st) ? x[4:0] : x[20:16];
        d.uses_r2 = is_cb || is_st || !(is_b || is_ld || is_i);
        d.is_load = is_ld;
        return d;
    endfunction

    function automatic logic [63:0] mread(logic [4:0] a, logic we, logic [4:0] wa,
                                          logic [63:0] wd);
        if (a == 5'd31) return 64'd0;
        if (BYP && we && (wa == a)) return wd;
        return m_regs[a];
    endfunction

    function automatic logic [4:0] pick_reg();
        int unsigned r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [4:0] a, b, c;
        a = pick_reg(); b = pick_reg(); c = pick_reg();
        case ($urandom_range(0, 7))
            0:       return {11'b11111000010, 9'($urandom), 2'b00, b, a};
            1:       return {11'b11111000000, 9'($urandom), 2'b00, b, a};
            2:       return {10'b1001000100, 12'($urandom), b, a};
            3:       return {10'b1101000100, 12'($urandom), b, a};
            4:       return {7'b1011010, 1'($urandom), 19'($urandom), a};
            5:       return {6'b000101, 26'($urandom)};
            6:       return {11'b10101010000, c, 6'($urandom), b, a};
            default: return {11'b10001011000, c, 6'd0, b, a};
        endcase
    endfunction

    vec_t tbl [13];

    initial begin
        rst_n = 1'b0;
        drive(32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // inst valid we wa wd | rdy vld imm rdata1 rdata2 rn r2 rd load
        tbl[0]  = mkv(32'h0, 0, 1, 5'd22, 64'd100, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(32'hF84402C9, 1, 0, 0, 0, 1, 1, 64'd64, 64'd100, 0, 22, 4, 9, 1);
        tbl[2]  = mkv(32'h8B09026A, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mkv(32'h8B09026A, 1, 0, 0, 0, 1, 1, 64'd0, 0, 0, 19, 9, 10, 0);
        tbl[4]  = mkv(32'hB4FFFF6B, 1, 0, 0, 0, 1, 1, 64'hFFFFFFFFFFFFFFFB, 0, 0, 27, 11, 11, 0);
        tbl[5]  = mkv(32'h17FFFFC9, 1, 0, 0, 0, 1, 1, 64'hFFFFFFFFFFFFFFC9, 0, 0, 30, 31, 9, 0);
        tbl[6]  = mkv(32'hAA150149, 1, 1, 5'd10, 64'd20, 1, 1, 64'd0, BYP ? 64'd20 : 64'd0,
                      0, 10, 21, 9, 0);
        tbl[7]  = mkv(32'h0, 0, 1, 5'd31, 64'd55, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mkv(32'h910017E1, 1, 0, 0, 0, 1, 1, 64'd5, 0, 0, 31, 0, 1, 0);
        tbl[9]  = mkv(32'hAA1F0142, 1, 0, 0, 0, 1, 1, 64'd0, 64'd20, 0, 10, 31, 2, 0);
        tbl[10] = mkv(32'hF81F82CA, 1, 0, 0, 0, 1, 1, 64'hFFFFFFFFFFFFFFF8, 64'd100, 64'd20,
                      22, 10, 10, 0);
        tbl[11] = mkv(32'hF84402DF, 1, 0, 0, 0, 1, 1, 64'd64, 64'd100, 0, 22, 4, 31, 1);
        tbl[12] = mkv(32'h8B1F026A, 1, 0, 0, 0, 1, 1, 64'd0, 0, 0, 19, 31, 10, 0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].inst, 64'h1000 + 64'(i * 4), tbl[i].valid, 1'b0, tbl[i].we,
                  tbl[i].wa, tbl[i].wd);
            #1;
            chk($sformatf("tbl%0d if_ready", i), 64'(if_ready), 64'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d ex_valid", i), 64'(ex_valid), 64'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d ex_pc", i), ex_pc, 64'h1000 + 64'(i * 4));
                chk($sformatf("tbl%0d ex_imm", i), ex_imm, tbl[i].imm);
                chk($sformatf("tbl%0d ex_rdata1", i), ex_rdata1, tbl[i].rd1);
                chk($sformatf("tbl%0d ex_rdata2", i), ex_rdata2, tbl[i].rd2);
                chk($sformatf("tbl%0d ex_rn", i), 64'(ex_rn), 64'(tbl[i].rn));
                chk($sformatf("tbl%0d ex_r2", i), 64'(ex_r2), 64'(tbl[i].r2));
                chk($sformatf("tbl%0d ex_rd", i), 64'(ex_rd), 64'(tbl[i].rd));
                chk($sformatf("tbl%0d ex_is_load", i), 64'(ex_is_load), 64'(tbl[i].ld));
            end
        end

        // Flush during a load-use stall drops the stalled instruction.
        drive(32'hF84402C9, 64'h2000, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        @(posedge clk); #1;
        chk("flush ld accepted", 64'(ex_valid), 64'd1);
        drive(32'h8B09026A, 64'h2004, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        #1;
        chk("flush stall if_ready", 64'(if_ready), 64'd0);
        flush = 1'b1;
        #1;
        chk("flush if_ready", 64'(if_ready), 64'd1);
        @(posedge clk); #1;
        chk("flush ex_valid", 64'(ex_valid), 64'd0);
        flush = 1'b0;
        #1;
        chk("post-flush if_ready", 64'(if_ready), 64'd1);
        @(posedge clk); #1;
        chk("post-flush ex_valid", 64'(ex_valid), 64'd1);
        chk("post-flush ex_rd", 64'(ex_rd), 64'd10);

        // Asynchronous reset in the middle of a stall.
        drive(32'hF84402C9, 64'h3000, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        @(posedge clk); #1;
        chk("mid-rst ld valid", 64'(ex_valid), 64'd1);
        drive(32'h8B09026A, 64'h3004, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        #1;
        chk("mid-rst stall if_ready", 64'(if_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("mid-rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(32'h910002C0, 64'h3008, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        @(posedge clk); #1;
        chk("post-rst ex_valid", 64'(ex_valid), 64'd1);
        chk("post-rst X22", ex_rdata1, 64'd0);
        chk("post-rst ex_rn", 64'(ex_rn), 64'd22);

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        drive(32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_ex = '{default: '0};
        begin
            logic [31:0] cur_inst;
            logic [63:0] cur_pc;
            logic        cur_valid, held, exp_rdy, haz, fl, we;
            logic [4:0]  wa;
            logic [63:0] wd;
            dec_t        d;
            mex_t        nx;
            held = 1'b0;
            cur_inst = 32'd0; cur_pc = 64'd0; cur_valid = 1'b0;
            for (int s = 0; s < 500; s++) begin
                if (!held) begin
                    cur_inst  = gen_inst();
                    cur_pc    = {$urandom, $urandom};
                    cur_valid = ($urandom_range(0, 9) != 0);
                end
                fl = ($urandom_range(0, 9) == 0);
                we = 1'($urandom);
                wa = pick_reg();
                wd = {$urandom, $urandom};
                drive(cur_inst, cur_pc, cur_valid, fl, we, wa, wd);
                #1;
                d   = mdec(cur_inst);
                haz = m_ex.valid && m_ex.is_load && (m_ex.rd != 5'd31) && cur_valid &&
                      ((d.rn == m_ex.rd) || (d.uses_r2 && (d.r2 == m_ex.rd)));
                exp_rdy = fl || !haz;
                chk($sformatf("rnd%0d if_ready", s), 64'(if_ready), 64'(exp_rdy));
                nx = m_ex;
                nx.valid = 1'b0;
                if (cur_valid && exp_rdy && !fl) begin
                    nx.valid   = 1'b1;
                    nx.is_load = d.is_load;
                    nx.pc      = cur_pc;
                    nx.rdata1  = mread(d.rn, we, wa, wd);
                    nx.rdata2  = mread(d.r2, we, wa, wd);
                    nx.imm     = d.imm;
                    nx.rd      = d.rd;
                    nx.rn      = d.rn;
                    nx.r2      = d.r2;
                end
                @(posedge clk); #1;
                m_ex = nx;
                if (we && (wa != 5'd31)) m_regs[wa] = wd;
                chk($sformatf("rnd%0d ex_valid", s), 64'(ex_valid), 64'(m_ex.valid));
                if (m_ex.valid) begin
                    chk($sformatf("rnd%0d ex_pc", s), ex_pc, m_ex.pc);
                    chk($sformatf("rnd%0d ex_rdata1", s), ex_rdata1, m_ex.rdata1);
                    chk($sformatf("rnd%0d ex_rdata2", s), ex_rdata2, m_ex.rdata2);
                    chk($sformatf("rnd%0d ex_imm", s), ex_imm, m_ex.imm);
                    chk($sformatf("rnd%0d ex_idx", s), 64'({ex_rd, ex_rn, ex_r2}),
                        64'({m_ex.rd, m_ex.rn, m_ex.r2}));
                    chk($sformatf("rnd%0d ex_is_load", s), 64'(ex_is_load), 64'(m_ex.is_load));
                end
                held = cur_valid && !exp_rdy;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Pipelined LEGv8 instruction-decode stage: parametrised register file with write-back port, immediate extraction and sign-extension for every LEGv8 format, load-use hazard detection with stall/bubble, and a registered ID/EX pipeline boundary. It sits between fetch (IF/ID handshake) and execute. It is the pipelined successor of the single-cycle ID block, which had fixed widths, external immediate handling and no hazard logic.

## Interface
- `XLEN`, default 64, datapath/register width
- `NREG`, default 32, register count; `AW = $clog2(NREG)`; highest index is XZR
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_valid`  in  1  `if_inst`/`if_pc` valid
- `if_ready`  out  1  stage accepts instruction this cycle
- `if_inst`  in  32  instruction word
- `if_pc`  in  XLEN  instruction PC
- `flush`  in  1  kill ID/EX contents and current ID instruction (taken branch)
- `wb_we`  in  1  register write enable
- `wb_addr`  in  AW  write register
- `wb_data`  in  XLEN  write data
- `ex_valid`  out  1  ID/EX entry valid
- `ex_pc`  out  XLEN  registered PC
- `ex_rdata1`  out  XLEN  Rn value
- `ex_rdata2`  out  XLEN  second operand (Rm or Rt)
- `ex_imm`  out  XLEN  extended immediate
- `ex_rd`, `ex_rn`, `ex_r2`  out  AW each  register indices
- `ex_is_load`  out  1  entry is LDUR

## Operation
- Format decode from opcode: B `inst[31:26]=000101`; CB `inst[31:24]=1011010x`; D `inst[31:21]` = 11111000010 (LDUR) or 11111000000 (STUR); I `inst[31:22]` = 1001000100 (ADDI) or 1101000100 (SUBI); anything else is R.
- Immediate: B → sext(`inst[25:0]`); CB → sext(`inst[23:5]`); D → sext(`inst[20:12]`); I → zext(`inst[21:10]`); R → zext(shamt `inst[15:10]`). Extended to XLEN; word offsets, no shift.
- Second read index: `inst[4:0]` (Rt) for CB and STUR, otherwise `inst[20:16]` (Rm). Rn = `inst[9:5]`; Rd = `inst[4:0]`.
- Register file: NREG×XLEN; reads are combinational; write on the rising edge when `wb_we`. Index NREG-1 (XZR) reads 0; writes to it are ignored.
- Load-use hazard: `ex_valid & ex_is_load & (ex_rd != XZR)` and the incoming valid instruction reads `ex_rd` as Rn, or as its second operand when that operand is used (R, D-STUR, CB). On a hazard: `if_ready=0` and a bubble is inserted (`ex_valid←0`). The hazard lasts exactly one cycle.
- `flush`: `ex_valid←0`, `if_ready=1` (the incoming instruction is dropped), and the hazard is ignored. Flush has priority over stall.
- Accept: `if_valid & if_ready & ~flush` latches all `ex_*` fields with `ex_valid←1`. Otherwise `ex_valid←0`, and the other fields may hold.

## Timing
- One-cycle latency: an instruction accepted at edge N appears on `ex_*` after edge N.
- `if_ready` is combinational from `if_inst` and the ID/EX register. Upstream holds `if_inst`/`if_pc` while `if_ready=0`.
- Reset (asynchronous, any time, including mid-stall): all `ex_*` = 0, `ex_valid=0`, all registers = 0. `if_ready` = 1 after reset.
- Write and read of the same register in the same cycle: see Configuration.

## Configuration
- `ID_BYPASS_EN` defined: a read whose index equals `wb_addr` while `wb_we=1` (index ≠ XZR) returns `wb_data` in the same cycle (write-through).
- Undefined: the read returns the old register content. The new value is visible from the next cycle.

## Structure
- Package `id_pkg`: format enum (`FMT_R`, `FMT_I`, `FMT_D`, `FMT_CB`, `FMT_B`), opcode constants (LDUR, STUR, ADDI, SUBI, CBZ/CBNZ, B), and an `id_ex_t` struct for the pipeline register.
- Sub-module `regfile_2r1w`: NREG/XLEN parametrised, 2 read ports, 1 write port, XZR handling, and bypass under `ID_BYPASS_EN`.
- Decode, immediate extraction, hazard logic and the ID/EX register live in the top.

## Test plan
- Reset, then preload X22=100 via WB. Send LDUR X9,[X22,#64] (0xF84402C9) → `ex_imm`=64, `ex_rn`=22, `ex_rdata1`=100, `ex_rd`=9, `ex_is_load`=1.
- Send ADD X10,X19,X9 (0x8B09026A) right after the LDUR → `if_ready`=0 for 1 cycle, and the bubble gives `ex_valid`=0. Next cycle ADD is issued with `ex_r2`=9, `ex_imm`=0.
- Send CBZ X11,-5 (0xB4FFFF6B) → `ex_imm`=0xFFFFFFFFFFFFFFFB, `ex_r2`=11. Send B -55 (0x17FFFFC9) → `ex_imm`=0xFFFFFFFFFFFFFFC9.
- Drive `wb_we`=1, `wb_addr`=10, `wb_data`=20 in the same cycle as ORR X9,X10,X21 (0xAA150149) → `ex_rdata1`=20 with `ID_BYPASS_EN`, 0 without. Both builds must be run.
- Write 55 to X31, then read Rn=31 → 0. Assert `flush` during a load-use stall → `ex_valid`=0, `if_ready`=1.
- Assert `rst_n`=0 mid-stream for 1 cycle → all outputs 0 immediately, and X22 reads 0 afterwards.
